// File: rtl/flag_selector.sv
// Flag selector controller: turns raw next/prev buttons and an optional
// slideshow timer into an 8-bit flag index that only moves on frame_tick,
// so the flag index stage never tears a frame between two flags.
module flag_selector #(
    parameter int unsigned DEBOUNCE_FRAMES = 2,
    parameter int unsigned AUTO_FRAMES     = 300
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_frame_tick,
    input  logic       i_btn_next,
    input  logic       i_btn_prev,
    input  logic       i_auto_en,
    input  logic [7:0] i_count,
    output logic [7:0] o_selector,
    output logic       o_changed
);

    // Debounce counter only has to reach DEBOUNCE_FRAMES-1 before it accepts.
    localparam int unsigned DB_W = (DEBOUNCE_FRAMES > 2) ? $clog2(DEBOUNCE_FRAMES) : 1;
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_FRAMES - 1);
    localparam logic [9:0]      AUTO_LAST = 10'(AUTO_FRAMES - 1);

    // Pending-step FSM encoding.
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_PEND_NEXT = 2'd1;
    localparam logic [1:0] ST_PEND_PREV = 2'd2;

    // Button vectors: bit 0 = next, bit 1 = prev.
    logic [1:0]      r_meta;
    logic [1:0]      r_sync;
    logic [1:0]      r_deb;
    logic [1:0]      w_deb_d;
    logic [DB_W-1:0] r_db_cnt   [2];
    logic [DB_W-1:0] w_db_cnt_d [2];
    logic [1:0]      w_press;

    logic [1:0] r_state;
    logic [1:0] w_state_base;
    logic [1:0] w_state_d;

    logic [9:0] r_auto_cnt;
    logic [9:0] w_auto_cnt_d;
    logic       w_auto_hit;

    logic       w_manual_next;
    logic       w_manual_prev;
    logic       w_manual;
    logic       w_step_next;
    logic       w_step_prev;

    logic [7:0] r_sel;
    logic [7:0] w_sel_d;
    logic [7:0] w_count_last;
    logic       r_changed;
    logic       w_changed_d;

    // Two-flop synchronizer for both asynchronous buttons.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= 2'b00;
            r_sync <= 2'b00;
        end else begin
            r_meta <= {i_btn_prev, i_btn_next};
            r_sync <= r_meta;
        end
    end

    // Per-button debounce, advanced only on frame_tick.
    always_comb begin
        w_deb_d       = r_deb;
        w_db_cnt_d[0] = r_db_cnt[0];
        w_db_cnt_d[1] = r_db_cnt[1];
        if (i_frame_tick) begin
            for (int b = 0; b < 2; b++) begin
                if (r_sync[b] != r_deb[b]) begin
                    if (r_db_cnt[b] == DB_LAST) begin
                        w_deb_d[b]    = r_sync[b];
                        w_db_cnt_d[b] = '0;
                    end else begin
                        w_db_cnt_d[b] = r_db_cnt[b] + DB_W'(1);
                    end
                end else begin
                    w_db_cnt_d[b] = '0;
                end
            end
        end
    end

    // A press is a rising edge of the debounced level; releases are ignored.
    assign w_press = w_deb_d & ~r_deb;

    // Debounced levels and counters.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_deb       <= 2'b00;
            r_db_cnt[0] <= '0;
            r_db_cnt[1] <= '0;
        end else begin
            r_deb       <= w_deb_d;
            r_db_cnt[0] <= w_db_cnt_d[0];
            r_db_cnt[1] <= w_db_cnt_d[1];
        end
    end

    // Pending FSM: the tick consumes the pending step, so presses seen on the
    // same tick are evaluated from IDLE and apply one frame later.
    always_comb begin
        w_state_base = i_frame_tick ? ST_IDLE : r_state;
        w_state_d    = w_state_base;
        case (w_state_base)
            ST_IDLE: begin
                if (w_press[0] && !w_press[1]) begin
                    w_state_d = ST_PEND_NEXT;
                end else if (w_press[1] && !w_press[0]) begin
                    w_state_d = ST_PEND_PREV;
                end
            end
            ST_PEND_NEXT: begin
                if (w_press[1]) begin
                    w_state_d = ST_IDLE;
                end
            end
            ST_PEND_PREV: begin
                if (w_press[0]) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    // Pending-state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    assign w_manual_next = i_frame_tick && (r_state == ST_PEND_NEXT);
    assign w_manual_prev = i_frame_tick && (r_state == ST_PEND_PREV);
    assign w_manual      = w_manual_next || w_manual_prev;
    assign w_auto_hit    = i_frame_tick && i_auto_en && (r_auto_cnt == AUTO_LAST);

    // Manual steps win over the slideshow; only one step per tick.
    assign w_step_next = w_manual_next || (w_auto_hit && !w_manual);
    assign w_step_prev = w_manual_prev;

    // Slideshow frame counter; a manual step restarts the dwell time.
    always_comb begin
        w_auto_cnt_d = r_auto_cnt;
        if (!i_auto_en || w_manual) begin
            w_auto_cnt_d = 10'd0;
        end else if (i_frame_tick) begin
            if (r_auto_cnt == AUTO_LAST) begin
                w_auto_cnt_d = 10'd0;
            end else begin
                w_auto_cnt_d = r_auto_cnt + 10'd1;
            end
        end
    end

    // Slideshow counter register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_auto_cnt <= 10'd0;
        end else begin
            r_auto_cnt <= w_auto_cnt_d;
        end
    end

    assign w_count_last = i_count - 8'd1;

    // Next selector: out-of-range values (empty or shrunk table) snap to 0 and
    // take precedence over any step, otherwise apply wrap-around stepping.
    always_comb begin
        w_sel_d = r_sel;
        if (i_frame_tick) begin
            if (i_count == 8'd0) begin
                w_sel_d = 8'd0;
            end else if (r_sel >= i_count) begin
                w_sel_d = 8'd0;
            end else if (w_step_next) begin
                w_sel_d = (r_sel == w_count_last) ? 8'd0 : r_sel + 8'd1;
            end else if (w_step_prev) begin
                w_sel_d = (r_sel == 8'd0) ? w_count_last : r_sel - 8'd1;
            end
        end
        w_changed_d = (w_sel_d != r_sel);
    end

    // Selector and change strobe update together so they are coincident.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sel     <= 8'd0;
            r_changed <= 1'b0;
        end else begin
            r_sel     <= w_sel_d;
            r_changed <= w_changed_d;
        end
    end

    assign o_selector = r_sel;
    assign o_changed  = r_changed;

endmodule

// File: tb/tb_flag_selector.sv
// Directed bench for flag_selector: expected selector values are queued when
// a step is provoked and checked whenever the DUT pulses changed.
module tb_flag_selector;

    logic       clk = 1'b0;
    logic       i_reset;
    logic       i_frame_tick;
    logic       i_btn_next;
    logic       i_btn_prev;
    logic       i_auto_en;
    logic [7:0] i_count;
    logic [7:0] o_selector;
    logic       o_changed;

    int n_total = 0;
    int n_bad   = 0;
    int exp_q[$];
    int mon_e;
    int m_sel;
    int m_count;
    int hold_v;

    always #5 clk = ~clk;

    flag_selector #(
        .DEBOUNCE_FRAMES(2),
        .AUTO_FRAMES    (4)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_frame_tick(i_frame_tick),
        .i_btn_next  (i_btn_next),
        .i_btn_prev  (i_btn_prev),
        .i_auto_en   (i_auto_en),
        .i_count     (i_count),
        .o_selector  (o_selector),
        .o_changed   (o_changed)
    );

    // Every changed pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (o_changed === 1'b1) begin
            n_total++;
            assert (exp_q.size() > 0) else begin
                n_bad++;
                $error("FAIL unexpected_changed: observed selector=%0d expected no pulse",
                       o_selector);
            end
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                n_total++;
                assert (o_selector === 8'(mon_e)) else begin
                    n_bad++;
                    $error("FAIL changed_value: observed=%0d expected=%0d", o_selector, mon_e);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int f_next(input int s, input int c);
        if (c == 0 || s >= c) return 0;
        return (s == c - 1) ? 0 : s + 1;
    endfunction

    function automatic int f_prev(input int s, input int c);
        if (c == 0 || s >= c) return 0;
        return (s == 0) ? c - 1 : s - 1;
    endfunction

    task automatic expect_sel(input int v);
        if (v != m_sel) exp_q.push_back(v);
        m_sel = v;
    endtask

    // One frame: idle time for the synchronizer, then a one-cycle tick.
    task automatic frame();
        repeat (3) @(negedge clk);
        i_frame_tick = 1'b1;
        @(negedge clk);
        i_frame_tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Hold buttons long enough to debounce, then release and let it settle.
    task automatic press(input logic nxt, input logic prv);
        i_btn_next = nxt;
        i_btn_prev = prv;
        frame();
        frame();
        i_btn_next = 1'b0;
        i_btn_prev = 1'b0;
        frame();
        frame();
    endtask

    task automatic step_next();
        expect_sel(f_next(m_sel, m_count));
        press(1'b1, 1'b0);
    endtask

    initial begin
        i_reset      = 1'b1;
        i_frame_tick = 1'b0;
        i_btn_next   = 1'b0;
        i_btn_prev   = 1'b0;
        i_auto_en    = 1'b0;
        i_count      = 8'd36;
        m_sel        = 0;
        m_count      = 36;
        repeat (3) @(negedge clk);
        chk("reset_selector", o_selector, 0);
        chk("reset_changed", o_changed, 0);
        i_reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_reset_selector", o_selector, 0);

        // Held button: pending after two ticks, applied on the third.
        expect_sel(f_next(m_sel, m_count));
        i_btn_next = 1'b1;
        frame();
        frame();
        chk("debounce_latency", o_selector, 0);
        frame();
        chk("hold_step", o_selector, 1);
        i_btn_next = 1'b0;
        frame();
        frame();
        chk("hold_single_step", o_selector, 1);
        chk("hold_queue", exp_q.size(), 0);

        // One-frame glitch is rejected.
        i_btn_next = 1'b1;
        frame();
        i_btn_next = 1'b0;
        frame();
        frame();
        frame();
        chk("glitch_selector", o_selector, 1);
        chk("glitch_queue", exp_q.size(), 0);

        // Prev down to 0, then wrap both ways.
        expect_sel(f_prev(m_sel, m_count));
        press(1'b0, 1'b1);
        chk("prev_step", o_selector, 0);
        expect_sel(f_prev(m_sel, m_count));
        press(1'b0, 1'b1);
        chk("prev_wrap", o_selector, 35);
        step_next();
        chk("next_wrap", o_selector, 0);
        chk("wrap_queue", exp_q.size(), 0);

        // Both buttons debounced on the same tick cancel.
        press(1'b1, 1'b1);
        chk("cancel_selector", o_selector, 0);
        chk("cancel_queue", exp_q.size(), 0);

        // Reach 5, leave a next pending, then reset mid-frame.
        for (int i = 0; i < 5; i++) step_next();
        chk("reach_five", o_selector, 5);
        i_btn_next = 1'b1;
        frame();
        frame();
        i_btn_next = 1'b0;
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        m_sel = 0;
        chk("midrun_reset_selector", o_selector, 0);
        chk("midrun_reset_changed", o_changed, 0);
        frame();
        frame();
        frame();
        chk("pending_discarded", o_selector, 0);
        chk("reset_queue", exp_q.size(), 0);

        // Count shrinks under the selector.
        for (int i = 0; i < 20; i++) step_next();
        chk("reach_twenty", o_selector, 20);
        i_count = 8'd10;
        m_count = 10;
        expect_sel(0);
        frame();
        chk("shrink_clamp", o_selector, 0);
        chk("shrink_queue", exp_q.size(), 0);

        // Empty table forces 0 and ignores buttons.
        step_next();
        step_next();
        chk("reach_two", o_selector, 2);
        i_count = 8'd0;
        m_count = 0;
        expect_sel(0);
        frame();
        chk("empty_force", o_selector, 0);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        chk("empty_ignore", o_selector, 0);
        chk("empty_queue", exp_q.size(), 0);

        // Slideshow: advance on every fourth tick, 0,1,2,0.
        i_count   = 8'd3;
        m_count   = 3;
        i_auto_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            hold_v = m_sel;
            expect_sel(f_next(m_sel, m_count));
            frame();
            frame();
            frame();
            chk("auto_hold", o_selector, hold_v);
            frame();
            chk("auto_step", o_selector, m_sel);
        end
        chk("auto_final", o_selector, 0);
        chk("auto_queue", exp_q.size(), 0);

        // Manual press lands on the auto tick: exactly one step.
        frame();
        i_btn_next = 1'b1;
        frame();
        frame();
        i_btn_next = 1'b0;
        expect_sel(f_next(m_sel, m_count));
        frame();
        chk("collide_single", o_selector, 1);
        frame();
        frame();
        frame();
        chk("collide_hold", o_selector, 1);
        expect_sel(f_next(m_sel, m_count));
        frame();
        chk("collide_next_auto", o_selector, 2);

        // Manual step mid-dwell restarts the auto counter.
        i_btn_next = 1'b1;
        frame();
        frame();
        i_btn_next = 1'b0;
        expect_sel(f_next(m_sel, m_count));
        frame();
        chk("midcount_manual", o_selector, 0);
        frame();
        frame();
        frame();
        chk("restart_hold", o_selector, 0);
        expect_sel(f_next(m_sel, m_count));
        frame();
        chk("restart_step", o_selector, 1);
        i_auto_en = 1'b0;
        frame();
        chk("final_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/flag_selector.md
Name: flag_selector

Overview:
- Upstream controller for the flag lookup stage: produces the 8-bit flag selector consumed by the flag index mux.
- Inputs are raw next/prev push-buttons and an optional auto-advance slideshow.
- The selector only changes on a frame boundary, so no frame tears between two flags.
- Sits between the board inputs / VGA sync generator and the flag index stage.

Parameters:
- DEBOUNCE_FRAMES, 2, number of consecutive frame_tick samples a synchronized button level must hold before it is accepted.
- AUTO_FRAMES, 300, frames per flag in auto mode (5 s at 60 Hz); legal range 1..1023.

Ports:
- clk  input  1  pixel clock
- reset  input  1  synchronous, active-high reset
- frame_tick  input  1  one-cycle pulse once per frame, at start of vertical blank
- btn_next  input  1  raw asynchronous button, active-high
- btn_prev  input  1  raw asynchronous button, active-high
- auto_en  input  1  auto-advance enable, quasi-static, sampled on frame_tick
- count  input  8  number of valid flags, from the flag index stage
- selector  output  8  registered flag index, to the flag index stage
- changed  output  1  one-cycle pulse in the cycle selector updates

Behaviour:
- Reset (synchronous, active-high; wins over all other inputs in the same cycle):
  - selector=0, changed=0.
  - Synchronizers, debounce counters, debounced levels, pending state and auto counter all cleared.
  - Reset asserted mid-frame discards any pending request.
- Input synchronization: each button passes through a 2-FF synchronizer on clk.
- Debounce, per button, evaluated only on frame_tick:
  - If the synchronized level differs from the debounced level, increment that button's counter.
  - On reaching DEBOUNCE_FRAMES, the debounced level takes the new value and the counter clears.
  - If the levels match, the counter clears.
- Press event: rising edge of the debounced level. Release events are ignored.
- Pending FSM, states IDLE, PEND_NEXT, PEND_PREV:
  - A next event moves IDLE to PEND_NEXT; a prev event moves IDLE to PEND_PREV.
  - The opposite event while pending returns to IDLE (cancel).
  - The same event while pending has no effect. One step per frame, no accumulation.
  - On frame_tick, the pending step is applied and the FSM returns to IDLE.
  - Debounce update and pending update happen in the same frame_tick cycle. A press detected on that tick is pending and applies on the next frame_tick, giving a one-frame minimum latency.
- Auto-advance:
  - 10-bit frame counter increments on frame_tick while auto_en=1.
  - When the counter reaches AUTO_FRAMES-1 on a frame_tick, it clears and an auto-next applies on that same tick.
  - Cleared whenever auto_en=0 and whenever a manual step applies.
  - Manual pending has priority: if both occur on one tick, exactly one step (the manual one) applies.
- Step arithmetic on frame_tick, using the count value sampled that cycle:
  - next: selector = (selector == count-1) ? 0 : selector+1.
  - prev: selector = (selector == 0) ? count-1 : selector-1.
  - count == 0: selector forced to 0; steps ignored; changed not asserted unless selector was nonzero.
  - selector >= count with no step (count shrank): clamp selector to 0 and pulse changed.
  - count == 1: next and prev both leave selector at 0; changed not asserted.
- changed: asserted for exactly one clk in the cycle after the frame_tick that altered selector, coincident with the new selector value. Never asserted when the value is unchanged.
- Between frame_ticks, selector is stable. No combinational path from any input to any output.

Test Plan:
- Reset with count=36 → selector=0, changed=0. Assert reset for one cycle mid-run at selector=5 → selector=0 on the next clk.
- DEBOUNCE_FRAMES=2: hold btn_next high across 3 frame_ticks → selector 0→1 exactly once, changed pulses once. A 1-frame glitch on btn_next → no change.
- Wrap: selector=35, count=36, next → 0. From selector=0, prev → 35.
- Cancel: next and prev debounced presses in the same frame window → selector unchanged, no changed pulse.
- AUTO_FRAMES=4, auto_en=1, count=3 → selector sequence 0,1,2,0 advancing every 4th frame_tick. A manual next on the auto tick → a single step only, and the auto counter restarts.
- count drops 36→10 while selector=20 → selector=0 on the next frame_tick with changed. count=0 → selector stays 0 regardless of buttons.
